// File: rtl/seq_det_pkg.sv
// Shared defaults and helpers for the serial sequence detector.
package seq_det_pkg;

  localparam int          DEF_PAT_W   = 3;
  localparam logic [2:0]  DEF_PATTERN = 3'b110;
  localparam int          DEF_CNT_W   = 8;

  // Width needed to hold a fill count in 0..pat_w inclusive.
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with registered match pulse.
// Match counter is built only when SEQ_DETECT_CNT_EN is defined; otherwise match_count is 0.
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEF_PATTERN),
  parameter int               OVERLAP = 1,
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clear,
  output logic             dout,
  output logic [CNT_W-1:0] match_count
);

  localparam int FW = fill_w(PAT_W);

  logic [PAT_W-1:0] hist;
  logic [PAT_W-1:0] window;
  logic [FW-1:0]    fill;
  logic [FW-1:0]    fill_nxt;
  logic             match;

  always_comb begin
    window   = (hist << 1) | PAT_W'(din);
    match    = din_valid && !clear && (fill >= FW'(PAT_W - 1)) && (window == PATTERN);
    fill_nxt = fill;
    // Non-overlapping mode discards the used bits so the next match needs a full fresh pattern.
    if (match && (OVERLAP == 0)) begin
      fill_nxt = '0;
    end else if (fill != FW'(PAT_W)) begin
      fill_nxt = fill + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist <= '0;
      fill <= '0;
      dout <= 1'b0;
    end else begin
      dout <= match;
      if (clear) begin
        hist <= '0;
        fill <= '0;
      end else if (din_valid) begin
        hist <= window;
        fill <= fill_nxt;
      end
    end
  end

`ifdef SEQ_DETECT_CNT_EN
  sat_counter #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (match),
    .q     (match_count)
  );
`else
  assign match_count = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Randomised and directed bench for seq_detect_param across four parameter sets.
module tb_seq_detect_param;

`ifdef SEQ_DETECT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam int PW   [4] = '{3, 4, 4, 3};
  localparam int PAT  [4] = '{6, 11, 11, 6};
  localparam int OVL  [4] = '{1, 1, 0, 1};
  localparam int CMAX [4] = '{255, 255, 255, 3};

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       clear = 1'b0;
  logic       dout_a [4];
  logic [7:0] mc0, mc1, mc2;
  logic [1:0] mc3;

  int checks = 0;
  int errors = 0;

  bit q [4][$];
  int cnt [4];
  int pulses [4];

  always #5 clk = ~clk;

  seq_detect_param dut0 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
    .dout(dout_a[0]), .match_count(mc0));

  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
    .dout(dout_a[1]), .match_count(mc1));

  seq_detect_param #(.PAT_W(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_W(8)) dut2 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
    .dout(dout_a[2]), .match_count(mc2));

  seq_detect_param #(.PAT_W(3), .PATTERN(3'b110), .OVERLAP(1), .CNT_W(2)) dut3 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .clear(clear),
    .dout(dout_a[3]), .match_count(mc3));

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int obs_count(input int i);
    case (i)
      0: return int'(mc0);
      1: return int'(mc1);
      2: return int'(mc2);
      default: return int'(mc3);
    endcase
  endfunction

  function automatic int obs_fill(input int i);
    case (i)
      0: return int'(dut0.fill);
      1: return int'(dut1.fill);
      2: return int'(dut2.fill);
      default: return int'(dut3.fill);
    endcase
  endfunction

  function automatic void model_restart();
    for (int i = 0; i < 4; i++) begin
      q[i].delete();
      cnt[i] = 0;
    end
  endfunction

  // Reference: keep the valid bits seen since the last restart; a match is the
  // newest PAT_W bits spelling the pattern.
  function automatic bit model_beat(input int i, input bit v, input bit d, input bit c);
    bit m;
    int n;
    m = 1'b0;
    if (c) begin
      q[i].delete();
      cnt[i] = 0;
    end else if (v) begin
      q[i].push_back(d);
      n = q[i].size();
      if (n >= PW[i]) begin
        m = 1'b1;
        for (int k = 0; k < PW[i]; k++)
          if (q[i][n - PW[i] + k] != bit'((PAT[i] >> (PW[i] - 1 - k)) & 1)) m = 1'b0;
      end
      if (m) begin
        if (cnt[i] < CMAX[i]) cnt[i]++;
        if (OVL[i] == 0) q[i].delete();
      end
      if (q[i].size() > PW[i]) void'(q[i].pop_front());
    end
    return m;
  endfunction

  task automatic step(input bit v, input bit d, input bit c);
    bit m;
    din = d;
    din_valid = v;
    clear = c;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      m = model_beat(i, v, d, c);
      if (dout_a[i]) pulses[i]++;
      check($sformatf("dout%0d", i), int'(dout_a[i]), int'(m));
      check($sformatf("count%0d", i), obs_count(i), CNT_EN ? cnt[i] : 0);
      check($sformatf("fill%0d", i), obs_fill(i), q[i].size());
    end
    din_valid = 1'b0;
    clear = 1'b0;
    din = $urandom_range(0, 1);
  endtask

  task automatic gap(input int n);
    for (int g = 0; g < n; g++) step(1'b0, 1'b1 ^ g[0], 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_restart();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_dout%0d", i), int'(dout_a[i]), 0);
      check($sformatf("rst_count%0d", i), obs_count(i), 0);
      check($sformatf("rst_fill%0d", i), obs_fill(i), 0);
    end
    #1;
    reset = 1'b0;
  endtask

  task automatic restart();
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) pulses[i] = 0;
  endtask

  initial begin
    bit seq_b [7] = '{1, 0, 1, 1, 0, 1, 1};
    #13;
    model_restart();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("init_dout%0d", i), int'(dout_a[i]), 0);
      check($sformatf("init_count%0d", i), obs_count(i), 0);
    end
    reset = 1'b0;

    // Default pattern 110 on 0,1,1,0
    restart();
    step(1, 0, 0); step(1, 1, 0); step(1, 1, 0);
    check("a_before", pulses[0], 0);
    step(1, 0, 0);
    check("a_pulse_now", int'(dout_a[0]), 1);
    step(0, 0, 0);
    check("a_pulse_gone", int'(dout_a[0]), 0);
    check("a_pulses", pulses[0], 1);
    check("a_count", int'(mc0), CNT_EN ? 1 : 0);

    // Overlap vs non-overlap on 1011011
    restart();
    for (int k = 0; k < 7; k++) step(1, seq_b[k], 0);
    check("b_ovl_pulses", pulses[1], 2);
    check("b_novl_pulses", pulses[2], 1);

    // Valid gaps with din toggling in between
    restart();
    step(1, 1, 0); gap(3); step(1, 1, 0); gap(3); step(1, 0, 0); gap(2);
    check("c_gap_pulses", pulses[0], 1);

    // Reset mid-pattern
    restart();
    step(1, 1, 0); step(1, 1, 0);
    do_reset();
    step(1, 0, 0);
    check("d_rst_pulses", pulses[0], 0);
    check("d_rst_fill", int'(dut0.fill), 1);

    // Clear colliding with the completing bit
    restart();
    step(1, 1, 0); step(1, 1, 0); step(1, 0, 1);
    step(0, 0, 0);
    check("e_clr_pulses", pulses[0], 0);
    check("e_clr_count", int'(mc0), 0);

    // Saturation with a 2-bit counter
    restart();
    for (int r = 0; r < 5; r++) begin
      step(1, 1, 0); step(1, 1, 0); step(1, 0, 0);
    end
    step(0, 0, 0);
    check("f_sat_pulses", pulses[3], 5);
    check("f_sat_count", int'(mc3), CNT_EN ? 3 : 0);
    check("f_wide_count", int'(mc0), CNT_EN ? 5 : 0);

    // Random traffic
    restart();
    for (int t = 0; t < 3000; t++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1), $urandom_range(0, 99) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 SHALL have parameter PAT_W, default 3, pattern length in bits; legal range 2..16.
REQ-002 SHALL have parameter PATTERN [PAT_W-1:0], default 3'b110, target sequence; MSB is the oldest bit.
REQ-003 SHALL have parameter OVERLAP, default 1, 1 = overlapping detection, 0 = non-overlapping.
REQ-004 SHALL have parameter CNT_W, default 8, width of the match counter.
REQ-005 SHALL have port clk  input  1  sole clock; all state updates on posedge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port din  input  1  serial data bit.
REQ-008 SHALL have port din_valid  input  1  qualifies din; no state change on cycles when low.
REQ-009 SHALL have port clear  input  1  synchronous restart of detection and counter.
REQ-010 SHALL have port dout  output  1  registered one-cycle match pulse.
REQ-011 SHALL have port match_count  output  CNT_W  saturating count of matches.

Function
REQ-012 SHALL keep history register hist[PAT_W-1:0] and fill counter fill in 0..PAT_W counting valid bits since the last restart.
REQ-013 SHALL, on a valid beat, form window = {hist[PAT_W-2:0], din}, load hist with window, and set fill to min(fill+1, PAT_W).
REQ-014 SHALL declare match on a valid beat when fill >= PAT_W-1 before the beat and window == PATTERN.
REQ-015 SHALL register dout <= match at the same edge; dout is high for exactly the cycle following the completing bit and low otherwise, including on all non-valid cycles.
REQ-016 SHALL, with OVERLAP=1, keep hist and the saturated fill after a match, so the pattern suffix is reused (PATTERN 1011, input 1011011 -> 2 matches).
REQ-017 SHALL, with OVERLAP=0, force fill to 0 on a match so the next match needs PAT_W fresh bits (PATTERN 1011, input 1011011 -> 1 match).
REQ-018 SHALL increment match_count by 1 on each match and hold it at 2^CNT_W-1 once saturated (no wrap).
REQ-019 SHALL give clear priority over din_valid: on a clear cycle hist=0, fill=0, dout=0, match_count=0, and the din beat is discarded.
REQ-020 SHALL ignore din when din_valid is low; hist, fill, and count hold.

Reset
REQ-021 SHALL, while reset is high, asynchronously force hist=0, fill=0, dout=0, match_count=0.
REQ-022 SHALL treat reset mid-pattern as a full restart; partial history is never matched after reset deasserts.
REQ-023 SHALL accept the first valid beat on the first posedge after reset deasserts.

Configuration
REQ-024 SHALL, when macro SEQ_DETECT_CNT_EN is defined, implement match_count per REQ-018.
REQ-025 SHALL, when SEQ_DETECT_CNT_EN is undefined, omit the counter logic and tie match_count to constant 0; dout behaviour is unchanged.

Structure
REQ-026 SHALL place default constants (PAT_W=3, PATTERN=3'b110, CNT_W=8) and the fill-counter width function in package seq_det_pkg.
REQ-027 SHALL implement the saturating counter as sub-module sat_counter (params W; ports clk, reset, clr, inc, q).

Verification
REQ-028 SHALL check defaults: din 0,1,1,0 with valid every cycle -> dout pulses once, the cycle after the 0; match_count=1.
REQ-029 SHALL check overlap: PATTERN=4'b1011, OVERLAP=1, din 1,0,1,1,0,1,1 -> 2 dout pulses; with OVERLAP=0 -> 1 pulse.
REQ-030 SHALL check valid gaps: 1,1,0 with din_valid low for 3 cycles between each bit and din toggling during the gaps -> exactly one pulse.
REQ-031 SHALL check reset mid-pattern: 1,1, then reset, then 0 -> no pulse; fill=1 after the 0.
REQ-032 SHALL check clear collision: clear and din_valid high on the completing 0 of 1,1,0 -> no pulse; match_count=0.
REQ-033 SHALL check saturation: CNT_W=2 with 5 matches -> match_count=3; with SEQ_DETECT_CNT_EN undefined -> match_count=0 and dout is unchanged.
